// File: rtl/lcd_bcd_writer.sv
// Writes four BCD digits as ASCII to an HD44780-style character LCD over an
// 8-bit write-only bus. It runs the power-up init once and redraws on request.
module lcd_bcd_writer #(
  parameter int unsigned POWERUP_CYCLES    = 750000,
  parameter int unsigned EN_PULSE_CYCLES   = 12,
  parameter int unsigned CMD_WAIT_CYCLES   = 2500,
  parameter int unsigned CLEAR_WAIT_CYCLES = 82000,
  parameter logic [7:0]  START_ADDR        = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic        update,
  output logic        busy,
  output logic        init_done,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e,
  output logic [7:0]  lcd_data
);

  localparam int unsigned MAX_AB = (POWERUP_CYCLES > EN_PULSE_CYCLES) ? POWERUP_CYCLES : EN_PULSE_CYCLES;
  localparam int unsigned MAX_CD = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW = $clog2(MAX_ALL + 1);

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t PWR_LAST = cnt_t'(POWERUP_CYCLES - 1);
  localparam cnt_t EN_LAST  = cnt_t'(EN_PULSE_CYCLES - 1);
  localparam cnt_t CMD_LAST = cnt_t'(CMD_WAIT_CYCLES - 1);
  localparam cnt_t CLR_LAST = cnt_t'(CLEAR_WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_PWR_WAIT, S_INIT, S_IDLE, S_XFER} state_t;
  typedef enum logic [1:0] {P_SETUP, P_PULSE, P_WAIT} phase_t;

  state_t      state_q;
  phase_t      phase_q;
  cnt_t        cnt_q;
  logic [2:0]  idx_q;
  logic        pending_q;
  logic [15:0] digits_q;
  logic        busy_q;
  logic        init_done_q;
  logic        lcd_rs_q;
  logic        lcd_e_q;
  logic [7:0]  lcd_data_q;

  function automatic logic [7:0] bcd_char(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h2D;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0:    return 8'h38;
      3'd1:    return 8'h0C;
      3'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  function automatic logic [7:0] xfer_byte(input logic [2:0] i, input logic [15:0] d);
    case (i)
      3'd0:    return {1'b1, START_ADDR[6:0]};
      3'd1:    return bcd_char(d[15:12]);
      3'd2:    return bcd_char(d[11:8]);
      3'd3:    return bcd_char(d[7:4]);
      default: return bcd_char(d[3:0]);
    endcase
  endfunction

  logic       in_xfer_d;
  logic [2:0] idx_next_d;
  logic [7:0] next_byte_d;
  cnt_t       wait_last_d;
  logic       last_slot_d;

  // Only the Clear command gets the long wait; data bytes never qualify.
  always_comb begin
    in_xfer_d   = (state_q == S_XFER);
    idx_next_d  = idx_q + 3'd1;
    next_byte_d = in_xfer_d ? xfer_byte(idx_next_d, digits_q) : init_cmd(idx_next_d);
    wait_last_d = (!lcd_rs_q && lcd_data_q == 8'h01) ? CLR_LAST : CMD_LAST;
    last_slot_d = in_xfer_d ? (idx_q == 3'd4) : (idx_q == 3'd3);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_PWR_WAIT;
      phase_q     <= P_SETUP;
      cnt_q       <= '0;
      idx_q       <= '0;
      pending_q   <= 1'b1;
      digits_q    <= '0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_e_q     <= 1'b0;
      lcd_data_q  <= 8'h00;
    end else begin
      pending_q <= pending_q | update;
      case (state_q)
        S_PWR_WAIT: begin
          busy_q <= 1'b1;
          if (cnt_q == PWR_LAST) begin
            state_q    <= S_INIT;
            phase_q    <= P_SETUP;
            cnt_q      <= '0;
            idx_q      <= '0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= init_cmd(3'd0);
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end

        S_IDLE: begin
          busy_q <= 1'b0;
          if (pending_q) begin
            pending_q  <= update;
            digits_q   <= digits;
            state_q    <= S_XFER;
            busy_q     <= 1'b1;
            phase_q    <= P_SETUP;
            cnt_q      <= '0;
            idx_q      <= '0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= xfer_byte(3'd0, digits);
          end
        end

        default: begin
          // Shared byte-slot engine for INIT and XFER: setup, strobe, wait.
          case (phase_q)
            P_SETUP: begin
              lcd_e_q <= 1'b1;
              phase_q <= P_PULSE;
              cnt_q   <= '0;
            end
            P_PULSE: begin
              if (cnt_q == EN_LAST) begin
                lcd_e_q <= 1'b0;
                phase_q <= P_WAIT;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + cnt_t'(1);
              end
            end
            default: begin
              if (cnt_q != wait_last_d) begin
                cnt_q <= cnt_q + cnt_t'(1);
              end else if (last_slot_d) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
                if (!in_xfer_d) init_done_q <= 1'b1;
              end else begin
                idx_q      <= idx_next_d;
                phase_q    <= P_SETUP;
                cnt_q      <= '0;
                lcd_rs_q   <= in_xfer_d;
                lcd_data_q <= next_byte_d;
              end
            end
          endcase
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = lcd_e_q;
  assign lcd_data  = lcd_data_q;

endmodule

// File: tb/tb_lcd_bcd_writer.sv
// Bench for lcd_bcd_writer: captures every strobed byte with its cycle number
// and compares against a hand-computed table, plus timing and reset checks.
module tb_lcd_bcd_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] digits = 16'h0930;
  logic        update = 1'b0;
  logic        busy, init_done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0]  lcd_data;

  always #5 clk = ~clk;

  lcd_bcd_writer #(
    .POWERUP_CYCLES(20),
    .EN_PULSE_CYCLES(2),
    .CMD_WAIT_CYCLES(5),
    .CLEAR_WAIT_CYCLES(10),
    .START_ADDR(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .digits(digits),
    .update(update),
    .busy(busy),
    .init_done(init_done),
    .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw),
    .lcd_e(lcd_e),
    .lcd_data(lcd_data)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct packed {
    logic        rs;
    logic [7:0]  data;
    logic [15:0] cyc;
  } rec_t;

  rec_t cap[$];
  rec_t tbl[34];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle number = posedges since the last reset release.
  always @(posedge clk) begin
    if (!rst) cyc = 0;
    else cyc++;
  end

  logic       e_prev = 1'b0;
  logic [8:0] bus_prev = 9'h0;
  logic       chg_pending = 1'b0;
  int         hi_cnt = 0;

  always @(negedge clk) begin
    check("rw_low", {31'h0, lcd_rw}, 32'h0);
    if (!rst) begin
      hi_cnt = 0;
      chg_pending = 1'b0;
    end else begin
      if (chg_pending) check("change_then_strobe", {31'h0, lcd_e && !e_prev}, 32'h1);
      chg_pending = 1'b0;
      if ({lcd_rs, lcd_data} != bus_prev) begin
        if (lcd_e) check("bus_stable_in_pulse", {23'h0, lcd_rs, lcd_data}, {23'h0, bus_prev});
        else chg_pending = 1'b1;
      end
      if (lcd_e && !e_prev) begin
        cap.push_back('{lcd_rs, lcd_data, 16'(cyc)});
        $display("strobe %0d: rs=%0d data=%02h cyc=%0d", cap.size() - 1, lcd_rs, lcd_data, cyc);
      end
      if (lcd_e) hi_cnt++;
      else if (e_prev) begin
        check("e_width", 32'(hi_cnt), 32'd2);
        hi_cnt = 0;
      end
    end
    e_prev = lcd_e;
    bus_prev = {lcd_rs, lcd_data};
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pulse_update();
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl = '{
      '{1'b0, 8'h38, 16'd21},  '{1'b0, 8'h0C, 16'd29},  '{1'b0, 8'h01, 16'd37},  '{1'b0, 8'h06, 16'd50},
      '{1'b0, 8'h80, 16'd59},  '{1'b1, 8'h30, 16'd67},  '{1'b1, 8'h39, 16'd75},  '{1'b1, 8'h33, 16'd83},
      '{1'b1, 8'h30, 16'd91},
      '{1'b0, 8'h80, 16'd103}, '{1'b1, 8'h2D, 16'd111}, '{1'b1, 8'h31, 16'd119}, '{1'b1, 8'h2D, 16'd127},
      '{1'b1, 8'h32, 16'd135},
      '{1'b0, 8'h80, 16'd153}, '{1'b1, 8'h31, 16'd161}, '{1'b1, 8'h32, 16'd169}, '{1'b1, 8'h33, 16'd177},
      '{1'b1, 8'h34, 16'd185},
      '{1'b0, 8'h80, 16'd194}, '{1'b1, 8'h30, 16'd202}, '{1'b1, 8'h30, 16'd210}, '{1'b1, 8'h30, 16'd218},
      '{1'b1, 8'h35, 16'd226},
      '{1'b0, 8'h80, 16'd243},
      '{1'b0, 8'h38, 16'd21},  '{1'b0, 8'h0C, 16'd29},  '{1'b0, 8'h01, 16'd37},  '{1'b0, 8'h06, 16'd50},
      '{1'b0, 8'h80, 16'd59},  '{1'b1, 8'h30, 16'd67},  '{1'b1, 8'h30, 16'd75},  '{1'b1, 8'h30, 16'd83},
      '{1'b1, 8'h35, 16'd91}
    };

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_lcd_e", {31'h0, lcd_e}, 32'h0);
    check("rst_lcd_data", {24'h0, lcd_data}, 32'h0);
    check("rst_lcd_rs", {31'h0, lcd_rs}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_init_done", {31'h0, init_done}, 32'h0);
    rst = 1'b1;

    // Init and automatic first redraw
    wait_cyc(19);
    check("pwr_busy", {31'h0, busy}, 32'h1);
    wait_cyc(56);
    check("init_done_early", {31'h0, init_done}, 32'h0);
    wait_cyc(57);
    check("init_done_rise", {31'h0, init_done}, 32'h1);
    check("idle_busy_57", {31'h0, busy}, 32'h0);
    for (int c = 58; c <= 97; c++) begin
      wait_cyc(c);
      check($sformatf("xfer_busy_%0d", c), {31'h0, busy}, 32'h1);
    end
    wait_cyc(98);
    check("busy_drop_98", {31'h0, busy}, 32'h0);

    // Invalid BCD redraw
    wait_cyc(100);
    digits = 16'hA1F2;
    pulse_update();
    check("accept_busy_101", {31'h0, busy}, 32'h0);
    wait_cyc(102);
    check("accept_busy_102", {31'h0, busy}, 32'h1);

    // Updates while busy collapse into one redraw, mid-transfer digit change ignored
    wait_cyc(150);
    digits = 16'h1234;
    pulse_update();
    wait_cyc(160);
    pulse_update();
    wait_cyc(165);
    digits = 16'h0005;
    wait_cyc(170);
    pulse_update();
    wait_cyc(180);
    pulse_update();
    wait_cyc(192);
    check("gap_busy_192", {31'h0, busy}, 32'h0);
    wait_cyc(193);
    check("rearm_busy_193", {31'h0, busy}, 32'h1);
    wait_cyc(233);
    check("final_busy_233", {31'h0, busy}, 32'h0);

    // Reset while lcd_e is high
    wait_cyc(240);
    pulse_update();
    wait_cyc(243);
    check("pre_rst_e", {31'h0, lcd_e}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_e", {31'h0, lcd_e}, 32'h0);
    check("async_rst_busy", {31'h0, busy}, 32'h0);
    check("async_rst_init_done", {31'h0, init_done}, 32'h0);
    check("async_rst_data", {24'h0, lcd_data}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_cyc(56);
    check("reinit_done_early", {31'h0, init_done}, 32'h0);
    wait_cyc(57);
    check("reinit_done", {31'h0, init_done}, 32'h1);
    wait_cyc(98);
    check("reredraw_busy_98", {31'h0, busy}, 32'h0);
    wait_cyc(120);

    check("strobe_count", 32'(cap.size()), 32'd34);
    for (int i = 0; i < 34; i++) begin
      if (i < cap.size()) begin
        check($sformatf("byte%0d_rs", i), {31'h0, cap[i].rs}, {31'h0, tbl[i].rs});
        check($sformatf("byte%0d_data", i), {24'h0, cap[i].data}, {24'h0, tbl[i].data});
        check($sformatf("byte%0d_cyc", i), {16'h0, cap[i].cyc}, {16'h0, tbl[i].cyc});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_bcd_writer.md
Name: lcd_bcd_writer

Overview:
- Downstream consumer of the BCD countdown digit chain. Takes four 4-bit digit values and writes them as ASCII characters to an HD44780-compatible character LCD over an 8-bit parallel, write-only bus.
- Performs the LCD power-up initialisation once after reset.
- On each update request, rewrites the four characters at a fixed DDRAM address, generating all E-strobe and command-wait timing from clk.

Parameters:
- POWERUP_CYCLES, 750000: clk cycles to wait after reset release before the first command (15 ms at 50 MHz).
- EN_PULSE_CYCLES, 12: clk cycles lcd_e is held high per byte.
- CMD_WAIT_CYCLES, 2500: clk cycles of wait after lcd_e falls, for every byte except Clear.
- CLEAR_WAIT_CYCLES, 82000: clk cycles of wait after lcd_e falls, for the Clear (0x01) command.
- START_ADDR, 8'h00: DDRAM address of the leftmost digit, 7-bit value.

Ports:
- clk, input, 1: system clock; all logic is on its rising edge.
- rst, input, 1: asynchronous active-low reset.
- digits, input, 16: [15:12] leftmost digit through [3:0] rightmost digit; sampled on update acceptance.
- update, input, 1: single-cycle request to redraw the digits.
- busy, output, 1: high whenever the FSM is not in IDLE.
- init_done, output, 1: high once the init sequence has completed; stays high until reset.
- lcd_rs, output, 1: 0 = command, 1 = data.
- lcd_rw, output, 1: tied 0 (write only).
- lcd_e, output, 1: LCD enable strobe.
- lcd_data, output, 8: LCD data bus.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0 (lcd_data=8'h00, busy=0, init_done=0).
  - FSM goes to PWR_WAIT, counters clear, pending=1.
- Reset asserted mid-operation aborts any transfer immediately. After release, the full init sequence restarts.
- States:
  - PWR_WAIT → INIT → IDLE.
  - IDLE → XFER (address byte, then 4 data bytes) → IDLE.
  - busy=1 in every state except IDLE.
- PWR_WAIT: counts POWERUP_CYCLES cycles from the first clk edge after rst release, then enters INIT.
- INIT sends these commands in order, each with lcd_rs=0:
  - 0x38 (function set)
  - 0x0C (display on)
  - 0x01 (clear)
  - 0x06 (entry mode)
- Byte slot timing, used for every byte:
  - 1 setup cycle: lcd_rs and lcd_data valid, lcd_e=0.
  - EN_PULSE_CYCLES cycles with lcd_e=1.
  - Wait phase with lcd_e=0: CLEAR_WAIT_CYCLES for 0x01, otherwise CMD_WAIT_CYCLES.
  - lcd_rs and lcd_data are held stable for the whole slot.
- init_done rises on the cycle after the last INIT slot ends, together with the entry into IDLE.
- Update handling:
  - An update pulse sets pending in any state.
  - In IDLE with pending=1: latch digits, clear pending, enter XFER. This takes one cycle; busy rises on the following cycle.
  - An update arriving while busy is remembered (pending) and causes exactly one further redraw. Multiple updates while busy collapse into one.
  - The latched value is used for the entire redraw; changes on digits mid-transfer are ignored.
  - pending=1 out of reset, so the first redraw happens automatically after init.
- XFER sends:
  - First slot: command 0x80 | START_ADDR, lcd_rs=0.
  - Then four data slots, lcd_rs=1, in order: leftmost digit [15:12] first, rightmost [3:0] last.
- Digit-to-character mapping:
  - Digit 0–9 → 8'h30 + digit.
  - Digit 10–15 (invalid BCD) → 8'h2D ('-').
- Counter widths must hold the largest parameter. With equal timing parameters no slot may be shortened or lengthened.
- After XFER completes, return to IDLE; busy drops on the cycle the FSM is in IDLE.

Test Plan:
Bench parameters: POWERUP_CYCLES=20, EN_PULSE_CYCLES=2, CMD_WAIT_CYCLES=5, CLEAR_WAIT_CYCLES=10. This gives an 8-cycle normal slot and a 13-cycle clear slot.

- Reset and init:
  - Stimulus: release rst, update held 0.
  - Required response:
    - lcd_e stays 0 for 20 cycles.
    - Then four strobes carry 0x38, 0x0C, 0x01, 0x06 with lcd_rs=0.
    - init_done rises 57 cycles after release.
- Automatic first redraw:
  - Stimulus: digits=16'h0930 during init.
  - Required response: after init, bytes 0x80, 0x30, 0x39, 0x33, 0x30 with rs = 0, 1, 1, 1, 1.
  - busy stays high for 40 cycles of XFER, then drops to 0.
- Invalid BCD:
  - Stimulus: digits=16'hA1F2, one update pulse in IDLE.
  - Required response: data bytes 0x2D, 0x31, 0x2D, 0x32.
- Update while busy:
  - Stimulus: three update pulses during one XFER; digits changed to 16'h0005 mid-transfer.
  - Required response:
    - The current redraw is unchanged.
    - Exactly one further redraw follows, sending 0x30, 0x30, 0x30, 0x35.
- Timing checks:
  - lcd_e high exactly 2 cycles per strobe.
  - lcd_data and lcd_rs stable from the setup cycle until the end of the wait phase.
  - lcd_rw is always 0.
- Reset mid-XFER:
  - Stimulus: assert rst while lcd_e=1.
  - Required response:
    - lcd_e, busy and init_done go to 0 immediately, without waiting for clk.
    - After release, the 20-cycle power-up wait and the full init sequence repeat.
